aurora_tx_frame_packer: RTL

- Per-channel upstream stage feeding one Aurora 8b10b TX AXI-Stream port (s_axi_tx_*), clocked by that channel's user clock.
- Buffers a raw 32-bit word stream from user logic and packs it into framed packets: sync word, header {seq, len}, payload, optional checksum trailer.
- Frames are emitted only while channel_up is high. A frame is aborted cleanly if the link drops mid-frame.

---
 rtl/aurora_tx_frame_packer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/aurora_tx_frame_packer.sv
// Buffers a raw 32-bit word stream and emits SYNC/HDR/payload frames to one Aurora TX AXI-Stream port.
// Define AURORA_TX_CHECKSUM_EN to append a 32-bit payload-sum trailer word to every frame.
module aurora_tx_frame_packer #(
   parameter int unsigned MAX_LEN    = 256,
   parameter int unsigned FIFO_DEPTH = 512,
   parameter logic [31:0] SYNC_WORD  = 32'hEB90_55AA,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        user_clk,
   input  logic        sys_rst_n,
   input  logic        channel_up,
   input  logic [31:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic        flush,
   output logic [31:0] s_axi_tx_tdata,
   output logic [3:0]  s_axi_tx_tkeep,
   output logic        s_axi_tx_tlast,
   output logic        s_axi_tx_tvalid,
   input  logic        s_axi_tx_tready,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt,
   output logic        busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

`ifdef AURORA_TX_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, SYNC, HDR, PAY, TRL, DRAIN} state_t;
   localparam bit CSUM_EN = 1'b1;
   logic [31:0] csum;
`else
   typedef enum logic [2:0] {IDLE, SYNC, HDR, PAY, DRAIN} state_t;
   localparam bit CSUM_EN = 1'b0;
`endif

   state_t        state;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_inc;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nx;
   logic [TW-1:0] tmo;
   logic          flush_pend;
   logic          flush_q;
   logic [15:0]   seq;
   logic [15:0]   len;
   logic [15:0]   len_c;
   logic [15:0]   pay_left;
   logic [31:0]   rd_next;
   logic          wr_en;
   logic          pop;
   logic          hs;
   logic          trigger;
   logic          abort;

   assign s_axi_tx_tkeep = 4'hF;

   assign wr_en      = din_valid && din_ready;
   assign hs         = s_axi_tx_tvalid && s_axi_tx_tready;
   assign flush_q    = flush_pend || flush;
   assign rd_ptr_inc = rd_ptr + AW'(1);
   assign rd_next    = mem[rd_ptr_inc];
   assign len_c      = (32'(count) >= MAX_LEN) ? 16'(MAX_LEN) : 16'(count);
   assign abort      = (state != IDLE) && (state != DRAIN) && !channel_up;

   // A payload word leaves the FIFO when it is accepted on the wire, or when drained after an abort.
   assign pop      = ((state == PAY) && hs && !abort) || ((state == DRAIN) && (pay_left != 16'd0));
   assign count_nx = count + CW'(wr_en) - CW'(pop);

   assign trigger = (state == IDLE) && channel_up && (count != '0) &&
                    ((32'(count) >= MAX_LEN) || flush_q || (tmo == TMO_MAX));

   // Payload storage; pointer/occupancy state lives in the reset domain below.
   always_ff @(posedge user_clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // FIFO pointers, occupancy, registered backpressure and the pending-flush latch.
   always_ff @(posedge user_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         din_ready  <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr_inc;
         count      <= count_nx;
         din_ready  <= (count_nx != CW'(FIFO_DEPTH));
         flush_pend <= (state == IDLE && channel_up) ? 1'b0 : flush_q;
      end
   end

   // Idle timeout; saturates so a stalled link cannot wrap it back to zero.
   always_ff @(posedge user_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tmo <= '0;
      end else if (wr_en || trigger || (count == '0)) begin
         tmo <= '0;
      end else if ((state == IDLE) && (tmo != TMO_MAX)) begin
         tmo <= tmo + TW'(1);
      end
   end

   // Framing FSM; the output register always holds the word currently offered on the wire.
   always_ff @(posedge user_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state           <= IDLE;
         busy            <= 1'b0;
         s_axi_tx_tdata  <= '0;
         s_axi_tx_tlast  <= 1'b0;
         s_axi_tx_tvalid <= 1'b0;
         seq             <= '0;
         frame_cnt       <= '0;
         drop_cnt        <= '0;
         len             <= '0;
         pay_left        <= '0;
`ifdef AURORA_TX_CHECKSUM_EN
         csum            <= '0;
`endif
      end else if (abort) begin
         state           <= DRAIN;
         busy            <= 1'b1;
         s_axi_tx_tvalid <= 1'b0;
         s_axi_tx_tlast  <= 1'b0;
         s_axi_tx_tdata  <= '0;
         drop_cnt        <= drop_cnt + 16'd1;
      end else begin
         unique case (state)
            IDLE: begin
               if (trigger) begin
                  state           <= SYNC;
                  busy            <= 1'b1;
                  len             <= len_c;
                  pay_left        <= len_c;
                  s_axi_tx_tdata  <= SYNC_WORD;
                  s_axi_tx_tlast  <= 1'b0;
                  s_axi_tx_tvalid <= 1'b1;
`ifdef AURORA_TX_CHECKSUM_EN
                  csum            <= '0;
`endif
               end
            end
            SYNC: begin
               if (hs) begin
                  state          <= HDR;
                  s_axi_tx_tdata <= {seq, len};
               end
            end
            HDR: begin
               if (hs) begin
                  state          <= PAY;
                  s_axi_tx_tdata <= mem[rd_ptr];
                  s_axi_tx_tlast <= !CSUM_EN && (len == 16'd1);
               end
            end
            PAY: begin
               if (hs) begin
                  pay_left <= pay_left - 16'd1;
`ifdef AURORA_TX_CHECKSUM_EN
                  csum     <= csum + s_axi_tx_tdata;
`endif
                  if (pay_left == 16'd1) begin
`ifdef AURORA_TX_CHECKSUM_EN
                     state          <= TRL;
                     s_axi_tx_tdata <= csum + s_axi_tx_tdata;
                     s_axi_tx_tlast <= 1'b1;
`else
                     state           <= IDLE;
                     busy            <= 1'b0;
                     s_axi_tx_tvalid <= 1'b0;
                     s_axi_tx_tlast  <= 1'b0;
                     seq             <= seq + 16'd1;
                     frame_cnt       <= frame_cnt + 16'd1;
`endif
                  end else begin
                     s_axi_tx_tdata <= rd_next;
                     s_axi_tx_tlast <= !CSUM_EN && (pay_left == 16'd2);
                  end
               end
            end
`ifdef AURORA_TX_CHECKSUM_EN
            TRL: begin
               if (hs) begin
                  state           <= IDLE;
                  busy            <= 1'b0;
                  s_axi_tx_tvalid <= 1'b0;
                  s_axi_tx_tlast  <= 1'b0;
                  seq             <= seq + 16'd1;
                  frame_cnt       <= frame_cnt + 16'd1;
               end
            end
`endif
            DRAIN: begin
               if (pay_left == 16'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  pay_left <= pay_left - 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
